// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
package piso_pkg;

    // Two-state frame controller: waiting for a word, or clocking one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width needed to count positions 0 .. width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one frame; flags the position of the final bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    // Clear has priority so a new frame always starts counting from bit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST);

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word LSB first with
// an active-low load strobe framing the valid bits, then pulses done.
// WIDTH must be at least 2.
module piso_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    output logic             ready,
    output logic             serial_out,
    output logic             load,
    output logic             done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_serial;
    logic             r_load;
    logic             r_done;

    logic             w_accept;
    logic             w_shifting;
    logic             w_more;
    logic             w_last;
    logic [CW-1:0]    w_count;

    // A start is only honoured while idle; in SHIFT both start and data_in
    // are ignored, so the word in flight cannot be disturbed.
    assign w_accept   = (r_state == IDLE) && start;
    assign w_shifting = (r_state == SHIFT);
    assign w_more     = (w_count < LAST);

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_accept | (w_shifting & w_last)),
        .i_enable (w_shifting & w_more),
        .o_count  (w_count),
        .o_last   (w_last)
    );

    // Frame controller: enter SHIFT on an accepted start, leave after the last bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (w_accept) begin
            r_state <= SHIFT;
        end else if (w_shifting && w_last) begin
            r_state <= IDLE;
        end
    end

    // Shift register: bit 0 always holds the bit currently on the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= data_in;
        end else if (w_shifting && w_more) begin
            r_shift <= r_shift >> 1;
        end
    end

    // Registered line outputs so the receiver never sees combinational glitches.
    // Bit 0 goes out on the accepting edge itself; each later edge presents the
    // next bit, which is r_shift[1] before the register moves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_serial <= 1'b0;
            r_load   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_serial <= data_in[0];
                r_load   <= 1'b0;
            end else if (w_shifting && w_last) begin
                r_serial <= 1'b0;
                r_load   <= 1'b1;
                r_done   <= 1'b1;
            end else if (w_shifting && w_more) begin
                r_serial <= r_shift[1];
            end
        end
    end

    assign ready      = (r_state == IDLE);
    assign serial_out = r_serial;
    assign load       = r_load;
    assign done       = r_done;

endmodule

// File: tb/tb_piso_transmitter.sv
// Bench for piso_transmitter: three instances (WIDTH 8, 2, 16) on one clock
// and reset. A receiver model per link shifts in serial_out on every cycle
// with load low and compares against a queue of accepted words on done.
module tb_piso_transmitter;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // serial_out in time order, leftmost bit first
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s  [3];
    logic [15:0] data_s   [3];
    logic        ready_s  [3];
    logic        serial_s [3];
    logic        load_s   [3];
    logic        done_s   [3];

    always #5 clk = ~clk;

    piso_transmitter #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(reset), .data_in(data_s[0][7:0]), .start(start_s[0]),
        .ready(ready_s[0]), .serial_out(serial_s[0]), .load(load_s[0]), .done(done_s[0])
    );
    piso_transmitter #(.WIDTH(2)) dut2 (
        .clock(clk), .reset(reset), .data_in(data_s[1][1:0]), .start(start_s[1]),
        .ready(ready_s[1]), .serial_out(serial_s[1]), .load(load_s[1]), .done(done_s[1])
    );
    piso_transmitter #(.WIDTH(16)) dut16 (
        .clock(clk), .reset(reset), .data_in(data_s[2]), .start(start_s[2]),
        .ready(ready_s[2]), .serial_out(serial_s[2]), .load(load_s[2]), .done(done_s[2])
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] exp_mem [3][256];
    int          wr_p [3];
    int          rd_p [3];
    vec_t        vecs [4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int ch);
        case (ch)
            0:       return 8;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int ch, input logic [15:0] d);
        exp_mem[ch][wr_p[ch] % 256] = d & 16'((32'd1 << w_of(ch)) - 1);
        wr_p[ch]++;
    endtask

    // Receiver and framing monitor for all three links.
    initial begin
        logic [15:0] rx  [3];
        int          run [3];
        logic        pd  [3];
        for (int ch = 0; ch < 3; ch++) begin
            rx[ch] = '0; run[ch] = 0; pd[ch] = 1'b0; wr_p[ch] = 0; rd_p[ch] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 3; ch++) begin
                if (reset === 1'b1) begin
                    rd_p[ch] = wr_p[ch];
                    rx[ch]   = '0;
                    run[ch]  = 0;
                    pd[ch]   = 1'b0;
                end else begin
                    if (load_s[ch] === 1'b0) begin
                        rx[ch] = (rx[ch] >> 1) | (16'(serial_s[ch]) << (w_of(ch) - 1));
                        run[ch]++;
                    end else if (run[ch] != 0) begin
                        chk($sformatf("ch%0d_load_low_len", ch), 32'(run[ch]), 32'(w_of(ch)));
                        run[ch] = 0;
                    end
                    if (done_s[ch] === 1'b1) begin
                        chk($sformatf("ch%0d_done_one_cycle", ch), 32'(pd[ch]), 32'd0);
                        if (rd_p[ch] == wr_p[ch]) begin
                            chk($sformatf("ch%0d_unexpected_done", ch), 32'(done_s[ch]), 32'd0);
                        end else begin
                            chk($sformatf("ch%0d_rx_word", ch), 32'(rx[ch]),
                                32'(exp_mem[ch][rd_p[ch] % 256]));
                            rd_p[ch]++;
                        end
                    end
                    pd[ch] = (done_s[ch] === 1'b1);
                end
            end
        end
    end

    // Directed WIDTH=8 frame starting at a negedge; returns at the done negedge.
    task automatic frame8(input logic [7:0] d, input logic [7:0] seq);
        chk("ready_before_start", 32'(ready_s[0]), 32'd1);
        start_s[0] = 1'b1;
        data_s[0]  = {8'h00, d};
        push(0, {8'h00, d});
        @(negedge clk);
        start_s[0] = 1'b0;
        data_s[0]  = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bit%0d_of_%02h", k, d), 32'(serial_s[0]), 32'(seq[7-k]));
            chk("load_low_in_frame", 32'(load_s[0]), 32'd0);
            chk("ready_low_in_frame", 32'(ready_s[0]), 32'd0);
            @(negedge clk);
        end
        chk("done_after_frame", 32'(done_s[0]), 32'd1);
        chk("load_high_after_frame", 32'(load_s[0]), 32'd1);
        chk("serial_zero_after_frame", 32'(serial_s[0]), 32'd0);
        chk("ready_after_frame", 32'(ready_s[0]), 32'd1);
    endtask

    task automatic random_frames(input int ch, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (ready_s[ch] !== 1'b1 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            chk($sformatf("ch%0d_ready_wait", ch), 32'(ready_s[ch]), 32'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_s[ch] = 1'b1;
            data_s[ch]  = 16'($urandom);
            push(ch, data_s[ch]);
            @(negedge clk);
            start_s[ch] = 1'b0;
            data_s[ch]  = 16'($urandom);
        end
        guard = 0;
        while (ready_s[ch] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk($sformatf("ch%0d_all_words_received", ch), 32'(rd_p[ch]), 32'(wr_p[ch]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        vecs[0] = '{data: 8'hA5, seq: 8'hA5};
        vecs[1] = '{data: 8'h01, seq: 8'h80};
        vecs[2] = '{data: 8'h12, seq: 8'h48};
        vecs[3] = '{data: 8'hF0, seq: 8'h0F};

        reset = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            start_s[ch] = 1'b0;
            data_s[ch]  = '0;
        end
        #1;
        for (int ch = 0; ch < 3; ch++) begin
            chk($sformatf("ch%0d_reset_ready", ch),  32'(ready_s[ch]),  32'd1);
            chk($sformatf("ch%0d_reset_load", ch),   32'(load_s[ch]),   32'd1);
            chk($sformatf("ch%0d_reset_serial", ch), 32'(serial_s[ch]), 32'd0);
            chk($sformatf("ch%0d_reset_done", ch),   32'(done_s[ch]),   32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Table-driven single frames.
        for (int i = 0; i < 4; i++) begin
            frame8(vecs[i].data, vecs[i].seq);
            @(negedge clk);
            chk("done_cleared", 32'(done_s[0]), 32'd0);
        end

        // Back-to-back: second start lands in the done cycle.
        frame8(8'h3C, 8'h3C);
        t1 = cyc;
        frame8(8'hFF, 8'hFF);
        t2 = cyc;
        chk("done_spacing", 32'(t2 - t1), 32'd9);
        @(negedge clk);

        // Start during SHIFT is ignored.
        chk("ready_before_81", 32'(ready_s[0]), 32'd1);
        start_s[0] = 1'b1;
        data_s[0]  = 16'h0081;
        push(0, 16'h0081);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) start_s[0] = 1'b0;
            chk("ready_low_81", 32'(ready_s[0]), 32'd0);
            chk("load_low_81", 32'(load_s[0]), 32'd0);
            if (c == 2) begin
                start_s[0] = 1'b1;
                data_s[0]  = 16'h0000;
            end
            if (c == 3) start_s[0] = 1'b0;
        end
        @(negedge clk);
        chk("done_81", 32'(done_s[0]), 32'd1);
        @(negedge clk);
        chk("no_frame_from_ignored_start", 32'(load_s[0]), 32'd1);

        // Reset mid-frame, then a clean frame.
        start_s[0] = 1'b1;
        data_s[0]  = 16'h005A;
        push(0, 16'h005A);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_load", 32'(load_s[0]), 32'd1);
        chk("midreset_serial", 32'(serial_s[0]), 32'd0);
        chk("midreset_done", 32'(done_s[0]), 32'd0);
        chk("midreset_ready", 32'(ready_s[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done_s[0]), 32'd0);
        end
        frame8(8'hC3, 8'hC3);
        @(negedge clk);

        // Randomised frames on all widths concurrently.
        fork
            random_frames(0, 10);
            random_frames(1, 30);
            random_frames(2, 15);
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
